// File: rtl/cbm2_bus_pkg.sv
// Shared types and defaults for the CBM-II bus sequencer.
package cbm2_bus_pkg;

  localparam int TICK_W         = 6;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int REQ_OFS_DEF    = 2;
  localparam int ACK_LIMIT_DEF  = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } bus_state_t;

  typedef enum logic {
    SLOT_VID = 1'b0,
    SLOT_CPU = 1'b1
  } slot_kind_t;

endpackage

// File: rtl/cbm2_cycle_counter.sv
// System-cycle tick counter with freeze; also exposes the next tick so the
// sequencer can register slot strobes aligned with the tick they belong to.
module cbm2_cycle_counter
  import cbm2_bus_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              freeze_i,
  output logic [TICK_W-1:0] tick_o,
  output logic [TICK_W-1:0] tick_nxt_o,
  output logic              phase_o
);

  localparam logic [TICK_W-1:0] LAST_T = TICK_W'(DIV_CYCLES - 1);
  localparam logic [TICK_W-1:0] HALF_T = TICK_W'(DIV_CYCLES / 2);
  localparam logic [TICK_W-1:0] ONE_T  = TICK_W'(1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              phase_q, phase_d;

  always_comb begin
    tick_d = tick_q;
    if (freeze_i) begin
      tick_d = tick_q;
    end else if (tick_q == LAST_T) begin
      tick_d = {TICK_W{1'b0}};
    end else begin
      tick_d = tick_q + ONE_T;
    end
    phase_d = (tick_d >= HALF_T);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q  <= {TICK_W{1'b0}};
      phase_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign tick_o     = tick_q;
  assign tick_nxt_o = tick_d;
  assign phase_o    = phase_q;

endmodule

// File: rtl/cbm2_bus_sequencer.sv
// CBM-II bus-cycle initiator: video/CPU slot strobes, DRAM handshake, CPU enable.
// CBM2_BUS_STRETCH_EN: on ack timeout, freeze the cycle until ack instead of flagging ram_err.
module cbm2_bus_sequencer
  import cbm2_bus_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int REQ_OFS    = REQ_OFS_DEF,
  parameter int ACK_LIMIT  = ACK_LIMIT_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cpu_halt,
  input  logic              cs_ram,
  input  logic              cpuWe,
  output logic              phase,
  output logic              vidCycle,
  output logic              cpuCycle,
  output logic              cpu_en,
  output logic              ram_req,
  output logic              ram_we,
  input  logic              ram_ack,
  output logic              ram_err,
  output logic [TICK_W-1:0] tick
);

`ifdef CBM2_BUS_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  localparam logic [TICK_W-1:0] HALF_T  = TICK_W'(DIV_CYCLES / 2);
  localparam logic [TICK_W-1:0] HLAST_T = TICK_W'(DIV_CYCLES / 2 - 1);
  localparam logic [TICK_W-1:0] REQ_T   = TICK_W'(REQ_OFS);
  localparam logic [7:0]        ACK_T   = 8'(ACK_LIMIT - 1);

  bus_state_t        state_q;
  logic              run_q, vid_q, cpu_q, cpu_en_q, req_q, we_q, err_q;
  logic [7:0]        wait_cnt_q;
  logic [TICK_W-1:0] tick_nxt_s, lpos_s;
  slot_kind_t        half_s;
  logic              stall_s, evt_s, half_start_s, half_last_s, done_now_s;

  // Counter holds at tick 0 for the first edge after reset so slot 0 starts aligned.
  cbm2_cycle_counter #(.DIV_CYCLES(DIV_CYCLES)) u_counter (
    .clk_i      (clk_sys),
    .rst_ni     (reset_n),
    .freeze_i   (!run_q || stall_s),
    .tick_o     (tick),
    .tick_nxt_o (tick_nxt_s),
    .phase_o    (phase)
  );

  always_comb begin
    half_s       = (tick_nxt_s >= HALF_T) ? SLOT_CPU : SLOT_VID;
    lpos_s       = (half_s == SLOT_CPU) ? (tick_nxt_s - HALF_T) : tick_nxt_s;
    half_start_s = (lpos_s == {TICK_W{1'b0}});
    half_last_s  = (lpos_s == HLAST_T);
    stall_s      = STRETCH && (state_q == HOLD) && !ram_ack;
    evt_s        = !stall_s;
    // Whether the slot is (or is becoming) finished on this edge.
    done_now_s   = 1'b0;
    case (state_q)
      ADDR:    done_now_s = (lpos_s == REQ_T) && !cs_ram;
      WAIT:    done_now_s = ram_ack || (!STRETCH && (wait_cnt_q == ACK_T));
      HOLD:    done_now_s = ram_ack;
      DONE:    done_now_s = 1'b1;
      default: done_now_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      vid_q      <= 1'b0;
      cpu_q      <= 1'b0;
      cpu_en_q   <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      run_q    <= 1'b1;
      cpu_en_q <= 1'b0;
      if (evt_s) begin
        vid_q <= (half_s == SLOT_VID);
        if (half_s == SLOT_VID) begin
          cpu_q <= 1'b0;
        end else if (half_start_s) begin
          cpu_q <= !cpu_halt;
        end else begin
          cpu_q <= cpu_q;
        end
        case (state_q)
          ADDR: begin
            if (lpos_s == REQ_T) begin
              if (cs_ram) begin
                req_q      <= 1'b1;
                we_q       <= cpuWe & cpu_q;
                wait_cnt_q <= 8'd0;
                state_q    <= WAIT;
              end else begin
                state_q <= DONE;
              end
            end
          end
          WAIT: begin
            if (ram_ack) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              state_q <= DONE;
            end else if (wait_cnt_q == ACK_T) begin
              if (STRETCH) begin
                state_q <= HOLD;
              end else begin
                err_q   <= 1'b1;
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                state_q <= DONE;
              end
            end else begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
          end
          HOLD: begin
            if (ram_ack) begin
              req_q   <= 1'b0;
              we_q    <= 1'b0;
              state_q <= DONE;
            end
          end
          IDLE, DONE: state_q <= state_q;
          default:    state_q <= IDLE;
        endcase
        if (half_last_s && done_now_s) begin
          state_q  <= IDLE;
          req_q    <= 1'b0;
          we_q     <= 1'b0;
          cpu_en_q <= (half_s == SLOT_CPU);
        end else if (half_start_s) begin
          state_q <= ((half_s == SLOT_VID) || !cpu_halt) ? ADDR : IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      end
    end
  end

  assign vidCycle = vid_q;
  assign cpuCycle = cpu_q;
  assign cpu_en   = cpu_en_q;
  assign ram_req  = req_q;
  assign ram_we   = we_q;
  assign ram_err  = err_q;

endmodule

// File: tb/tb_cbm2_bus_sequencer.sv
// Directed-vector bench for cbm2_bus_sequencer at default parameters.
module tb_cbm2_bus_sequencer;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_halt = 1'b0, cs_ram = 1'b0, cpuWe = 1'b0, ram_ack = 1'b0;
  logic       phase, vidCycle, cpuCycle, cpu_en, ram_req, ram_we, ram_err;
  logic [5:0] tick;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t0;

  cbm2_bus_sequencer dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cpu_halt (cpu_halt),
    .cs_ram   (cs_ram),
    .cpuWe    (cpuWe),
    .phase    (phase),
    .vidCycle (vidCycle),
    .cpuCycle (cpuCycle),
    .cpu_en   (cpu_en),
    .ram_req  (ram_req),
    .ram_we   (ram_we),
    .ram_ack  (ram_ack),
    .ram_err  (ram_err),
    .tick     (tick)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance at least one cycle, then until tick == t (bounded).
  task automatic wait_tick(input int t);
    int n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while ((int'(tick) != t) && (n < 200));
    if (int'(tick) != t) check_val("wait_tick", int'(tick), t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    check_val("rst_tick", int'(tick), 0);
    check_val("rst_phase", int'(phase), 0);
    check_val("rst_vid", int'(vidCycle), 0);
    check_val("rst_cpu", int'(cpuCycle), 0);
    check_val("rst_en", int'(cpu_en), 0);
    check_val("rst_req", int'(ram_req), 0);
    check_val("rst_err", int'(ram_err), 0);
    reset_n = 1'b1;

    // Plain cycle after release, no DRAM.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_sys);
      check_val("a_tick", int'(tick), i);
      check_val("a_vid", int'(vidCycle), (i < 16) ? 1 : 0);
      check_val("a_cpu", int'(cpuCycle), (i >= 16) ? 1 : 0);
      check_val("a_phase", int'(phase), (i >= 16) ? 1 : 0);
      check_val("a_en", int'(cpu_en), (i == 31) ? 1 : 0);
      check_val("a_req", int'(ram_req), 0);
    end
    @(negedge clk_sys);
    check_val("a_wrap", int'(tick), 0);

    // CPU write with ack 3 ticks after request.
    wait_tick(17);
    cs_ram = 1'b1; cpuWe = 1'b1;
    for (int t = 18; t <= 21; t++) begin
      wait_tick(t);
      check_val("b_req", int'(ram_req), 1);
      check_val("b_we", int'(ram_we), 1);
      cs_ram = 1'b0;
      if (t == 21) ram_ack = 1'b1;
    end
    wait_tick(22);
    ram_ack = 1'b0;
    check_val("b_req_drop", int'(ram_req), 0);
    wait_tick(31);
    check_val("b_en", int'(cpu_en), 1);

    // Video slot DRAM request never writes.
    cs_ram = 1'b1;
    for (int t = 2; t <= 4; t++) begin
      wait_tick(t);
      check_val("c_req", int'(ram_req), 1);
      check_val("c_we", int'(ram_we), 0);
      cs_ram = 1'b0;
      if (t == 4) ram_ack = 1'b1;
    end
    wait_tick(5);
    ram_ack = 1'b0;
    check_val("c_req_drop", int'(ram_req), 0);

    // Halted CPU half; stray ack is ignored.
    cpuWe = 1'b0;
    wait_tick(15);
    cpu_halt = 1'b1;
    wait_tick(16);
    cpu_halt = 1'b0;
    check_val("d_cpu16", int'(cpuCycle), 0);
    check_val("d_phase", int'(phase), 1);
    wait_tick(20);
    ram_ack = 1'b1;
    wait_tick(21);
    ram_ack = 1'b0;
    check_val("d_req", int'(ram_req), 0);
    wait_tick(31);
    check_val("d_cpu31", int'(cpuCycle), 0);
    check_val("d_en", int'(cpu_en), 0);
    wait_tick(0);
    check_val("d_vid", int'(vidCycle), 1);
    wait_tick(16);
    check_val("d_cpu_next", int'(cpuCycle), 1);
    wait_tick(31);
    check_val("d_en_next", int'(cpu_en), 1);

    // Ack coinciding with the timeout edge is a success.
    wait_tick(17);
    cs_ram = 1'b1;
    wait_tick(18);
    cs_ram = 1'b0;
    check_val("e0_req", int'(ram_req), 1);
    wait_tick(29);
    check_val("e0_req29", int'(ram_req), 1);
    ram_ack = 1'b1;
    wait_tick(30);
    ram_ack = 1'b0;
    check_val("e0_req_drop", int'(ram_req), 0);
    check_val("e0_err", int'(ram_err), 0);
    wait_tick(31);
    check_val("e0_en", int'(cpu_en), 1);

    // Missing ack.
    wait_tick(16);
    t0 = cyc;
    cs_ram = 1'b1;
    wait_tick(18);
    cs_ram = 1'b0;
    check_val("e_req", int'(ram_req), 1);
    wait_tick(29);
    check_val("e_req29", int'(ram_req), 1);
    check_val("e_err29", int'(ram_err), 0);
    wait_tick(30);
`ifdef CBM2_BUS_STRETCH_EN
    check_val("e_hold_req", int'(ram_req), 1);
    repeat (7) @(negedge clk_sys);
    check_val("e_frozen", int'(tick), 30);
    @(negedge clk_sys);
    check_val("e_frozen2", int'(tick), 30);
    ram_ack = 1'b1;
    @(negedge clk_sys);
    ram_ack = 1'b0;
    check_val("e_tick31", int'(tick), 31);
    check_val("e_req_drop", int'(ram_req), 0);
    check_val("e_en", int'(cpu_en), 1);
    check_val("e_err", int'(ram_err), 0);
    wait_tick(16);
    check_val("e_period", cyc - t0, 40);
`else
    check_val("e_err", int'(ram_err), 1);
    check_val("e_req_drop", int'(ram_req), 0);
    wait_tick(31);
    check_val("e_en", int'(cpu_en), 1);
    wait_tick(16);
    check_val("e_period", cyc - t0, 32);
`endif

    // Reset in the middle of WAIT.
    wait_tick(17);
    cs_ram = 1'b1;
    wait_tick(19);
    cs_ram = 1'b0;
    check_val("f_req", int'(ram_req), 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("f_req_async", int'(ram_req), 0);
    check_val("f_tick", int'(tick), 0);
    check_val("f_vid", int'(vidCycle), 0);
    check_val("f_err", int'(ram_err), 0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check_val("f_tick0", int'(tick), 0);
    check_val("f_vid0", int'(vidCycle), 1);
    check_val("f_cpu0", int'(cpuCycle), 0);
    @(negedge clk_sys);
    check_val("f_tick1", int'(tick), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
